buzz_pattern_ctrl: RTL
======================

Name: buzz_pattern_ctrl

Overview:
- Avalon-MM slave that sequences the alarm buzzer output.
- Generates timed ON/OFF beep bursts with a programmable repeat count, an optional square-wave tone during ON, and a completion interrupt.
- Replaces software bit-banging of the buzzer PIO.
- Sits in the CPU1 system; out_port drives the buzzer pin directly.

Parameters:
- CNT_W, 24, width of the ON_TICKS, OFF_TICKS and TONE_HALF registers and of the phase/tone counters.
- REP_W, 16, width of the REPEAT register and of the remaining-repeat counter (REP_W ≤ 16).

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- address  input  3  register select: 0 CTRL, 1 ON_TICKS, 2 OFF_TICKS, 3 REPEAT, 4 TONE_HALF, 5 STATUS.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  read data; zero wait, combinational from address.
- out_port  output  1  buzzer drive, registered.
- irq  output  1  level interrupt = STATUS.DONE & CTRL.IRQ_EN.

Behaviour:
- Write strobe: chipselect & ~write_n.
- Reset values: all registers, counters and STATUS are 0; state IDLE; out_port 0; irq 0.
- CTRL register:
  - bit0 START, self-clearing, reads 0.
  - bit1 STOP, self-clearing, reads 0.
  - bit3 IRQ_EN, stored.
- Config registers:
  - ON_TICKS, OFF_TICKS and TONE_HALF are read/write, CNT_W bits, zero-extended on read.
  - REPEAT is REP_W bits.
- Zero clamp: a zero in ON_TICKS or OFF_TICKS is treated as 1 when loaded.
- States: IDLE, ON, OFF.
- START in IDLE (write in cycle n):
  - rem ← REPEAT, phase counter ← ON_TICKS, DONE cleared.
  - State is ON in cycle n+1; out_port is 1 from cycle n+1.
- ON phase:
  - Lasts exactly ON_TICKS cycles, then OFF.
  - OFF lasts exactly OFF_TICKS cycles with out_port 0.
- End of OFF:
  - If REPEAT was 0 at start (continuous mode): return to ON indefinitely.
  - Otherwise rem decrements. rem becomes 0 → IDLE and DONE set. Else → ON.
- Register update timing:
  - ON_TICKS and OFF_TICKS are sampled at each phase entry, so writes while busy take effect at the next phase.
  - REPEAT is sampled only at START.
- Tone during ON:
  - TONE_HALF=0 → out_port steadily 1.
  - Otherwise out_port starts at 1 on phase entry and toggles every TONE_HALF cycles.
  - The tone counter restarts at each ON entry.
- STOP:
  - From any state → IDLE next cycle; out_port 0 next cycle.
  - DONE not set; rem cleared.
- Conflicting commands:
  - START and STOP in the same write: STOP wins.
  - START while ON/OFF: ignored; no restart, counters undisturbed.
- STATUS read:
  - bit0 BUSY (state≠IDLE).
  - bit1 DONE, sticky.
  - bit2 PHASE_ON.
  - bits[31:16] rem, zero-extended.
- STATUS write: writing 1 to bit1 clears DONE. DONE being set in the same cycle wins over the clear.
- Reads have no side effects; unused addresses read 0, and writes to them are ignored.
- Reset asserted mid-pattern: immediate return to reset values, including out_port 0 asynchronously.

Test Plan:
1. ON=3, OFF=2, REPEAT=2, TONE=0, IRQ_EN=1, START → out_port 1,1,1,0,0,1,1,1,0,0 from cycle n+1. DONE=1 and irq=1 at cycle n+11. BUSY=0 after.
2. ON=4, OFF=4, REPEAT=0, START → pattern repeats for 10 periods with BUSY=1 and DONE never set. STOP → out_port 0 and BUSY=0 the next cycle.
3. ON=8, TONE_HALF=2, REPEAT=1 → out_port during ON reads 1,1,0,0,1,1,0,0, then 0 through OFF. STATUS[31:16] steps 1→0 at the end.
4. ON=0, OFF=0, REPEAT=3 → clamped to 1/1, giving out_port 1,0,1,0,1,0 then DONE.
5. Single write with START+STOP while IDLE → stays IDLE, out_port 0. START while busy → pattern phase unchanged.
6. reset asserted mid-ON with REPEAT=5 → out_port 0, readdata STATUS=0, irq 0 immediately. After release a new START runs the full pattern. Also: a DONE clear written in the same cycle DONE sets → DONE reads 1.

Source files
------------

// File: rtl/buzz_pattern_ctrl.sv
// Buzzer pattern sequencer behind an Avalon-MM slave.
// It produces timed ON/OFF bursts, with an optional tone during ON and a done interrupt.
module buzz_pattern_ctrl #(
    parameter int CNT_W = 24,
    parameter int REP_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_port,
    output logic        irq
);

    // state  | meaning
    // S_IDLE | no pattern running, out_port low
    // S_ON   | beep phase, out_port high or toning
    // S_OFF  | silent gap between beeps
    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   on_ticks, off_ticks, tone_half;
    logic [REP_W-1:0]   repeat_cfg, rem;
    logic [CNT_W-1:0]   phase_cnt, tone_cnt;
    logic               irq_en, done, cont_mode;

    logic               wr_en, cmd_start, cmd_stop, wr_status;
    logic               phase_tc;
    logic               start_load, enter_on, enter_off, dec_rem, set_done;
    logic [CNT_W-1:0]   on_load, off_load;
    logic [15:0]        rem_ext;
    logic               unused_wdata;

    assign wr_en     = chipselect & ~write_n;
    assign cmd_start = wr_en && (address == 3'd0) && writedata[0];
    assign cmd_stop  = wr_en && (address == 3'd0) && writedata[1];
    assign wr_status = wr_en && (address == 3'd5) && writedata[1];
    assign phase_tc  = (phase_cnt == CNT_ONE);

    // A zero phase length would never reach terminal count, so it runs as one tick.
    assign on_load  = (on_ticks  == '0) ? CNT_ONE : on_ticks;
    assign off_load = (off_ticks == '0) ? CNT_ONE : off_ticks;

    assign unused_wdata = ^{writedata, 1'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start_load = 1'b0;
        enter_on   = 1'b0;
        enter_off  = 1'b0;
        dec_rem    = 1'b0;
        set_done   = 1'b0;
        if (cmd_stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        state_nxt  = S_ON;
                        start_load = 1'b1;
                        enter_on   = 1'b1;
                    end
                end
                S_ON: begin
                    if (phase_tc) begin
                        state_nxt = S_OFF;
                        enter_off = 1'b1;
                    end
                end
                S_OFF: begin
                    if (phase_tc) begin
                        if (cont_mode) begin
                            state_nxt = S_ON;
                            enter_on  = 1'b1;
                        end else begin
                            dec_rem = 1'b1;
                            if (rem == REP_ONE) begin
                                state_nxt = S_IDLE;
                                set_done  = 1'b1;
                            end else begin
                                state_nxt = S_ON;
                                enter_on  = 1'b1;
                            end
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            on_ticks   <= '0;
            off_ticks  <= '0;
            tone_half  <= '0;
            repeat_cfg <= '0;
            irq_en     <= 1'b0;
        end else if (wr_en) begin
            case (address)
                3'd0: irq_en     <= writedata[3];
                3'd1: on_ticks   <= writedata[CNT_W-1:0];
                3'd2: off_ticks  <= writedata[CNT_W-1:0];
                3'd3: repeat_cfg <= writedata[REP_W-1:0];
                3'd4: tone_half  <= writedata[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_cnt <= '0;
            tone_cnt  <= '0;
            rem       <= '0;
            cont_mode <= 1'b0;
            done      <= 1'b0;
            out_port  <= 1'b0;
        end else begin
            if (cmd_stop) begin
                phase_cnt <= '0;
                tone_cnt  <= '0;
            end else if (enter_on) begin
                phase_cnt <= on_load;
                tone_cnt  <= tone_half;
            end else if (enter_off) begin
                phase_cnt <= off_load;
            end else if (state != S_IDLE) begin
                phase_cnt <= phase_cnt - CNT_ONE;
            end

            // Tone reload happens on the toggle cycle so each half-period is exact.
            if (!cmd_stop && !enter_on && state == S_ON && tone_cnt != '0) begin
                if (tone_cnt == CNT_ONE) tone_cnt <= tone_half;
                else                     tone_cnt <= tone_cnt - CNT_ONE;
            end

            if (cmd_stop) begin
                rem       <= '0;
                cont_mode <= 1'b0;
            end else if (start_load) begin
                rem       <= repeat_cfg;
                cont_mode <= (repeat_cfg == '0);
            end else if (dec_rem) begin
                rem <= rem - REP_ONE;
            end

            if (set_done)        done <= 1'b1;
            else if (start_load) done <= 1'b0;
            else if (wr_status)  done <= 1'b0;

            if (cmd_stop || enter_off || set_done)
                out_port <= 1'b0;
            else if (enter_on)
                out_port <= 1'b1;
            else if (state == S_ON && tone_cnt == CNT_ONE)
                out_port <= ~out_port;
        end
    end

    assign rem_ext = 16'(rem);
    assign irq     = done & irq_en;

    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata = {28'd0, irq_en, 3'd0};
            3'd1: readdata = 32'(on_ticks);
            3'd2: readdata = 32'(off_ticks);
            3'd3: readdata = 32'(repeat_cfg);
            3'd4: readdata = 32'(tone_half);
            3'd5: readdata = {rem_ext, 13'd0, (state == S_ON), done, (state != S_IDLE)};
            default: readdata = '0;
        endcase
    end

endmodule
